// File: rtl/shape_calc_engine_if.sv
// Command/result handshake bundle between the shape SFR stage and shape_calc_engine.
interface shape_calc_engine_if #(
    parameter int unsigned W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_shape;
    logic [4:0]       cmd_operation;
    logic [W-1:0]     side_a;
    logic [W-1:0]     side_b;
    logic [W-1:0]     side_c;
    logic             res_valid;
    logic             res_ready;
    logic [2*W-1:0]   res_data;
    logic             res_error;

    modport master (
        output cmd_valid, cmd_shape, cmd_operation, side_a, side_b, side_c, res_ready,
        input  cmd_ready, res_valid, res_data, res_error
    );

    modport slave (
        input  cmd_valid, cmd_shape, cmd_operation, side_a, side_b, side_c, res_ready,
        output cmd_ready, res_valid, res_data, res_error
    );
endinterface

// File: rtl/shape_calc_engine.sv
// Shape execution stage: legality check, perimeter/area/predicate, valid/ready result.
// SHAPE_CALC_MUL_1CYC_EN selects a combinational area multiply instead of the W-cycle shift-add.
module shape_calc_engine #(
    parameter int unsigned W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    shape_calc_engine_if.slave   bus
);
    localparam int unsigned RW = 2 * W;
`ifndef SHAPE_CALC_MUL_1CYC_EN
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
`endif

    localparam logic [1:0] SH_RECT  = 2'b01;
    localparam logic [1:0] SH_TRI   = 2'b10;
    localparam logic [4:0] OP_PERIM = 5'b00000;
    localparam logic [4:0] OP_AREA  = 5'b00001;
    localparam logic [4:0] OP_SQ    = 5'b01000;
    localparam logic [4:0] OP_EQ    = 5'b10000;
    localparam logic [4:0] OP_ISO   = 5'b10001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifndef SHAPE_CALC_MUL_1CYC_EN
        S_MUL  = 2'd1,
`endif
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            res_valid_q, res_valid_d;
    logic [RW-1:0]   res_data_q, res_data_d;
    logic            res_error_q, res_error_d;
`ifndef SHAPE_CALC_MUL_1CYC_EN
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tri_q, tri_d;
    logic [RW-1:0]   sum_c;
`endif

    logic            accept_c;
    logic            is_rect_c;
    logic            is_tri_c;
    logic            legal_c;
    logic            is_area_c;
    logic [RW-1:0]   ext_a_c;
    logic [RW-1:0]   ext_b_c;
    logic [RW-1:0]   ext_c_c;
    logic [RW-1:0]   direct_res_c;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_error = res_error_q;

    assign accept_c  = bus.cmd_valid && cmd_ready_q;
    assign is_rect_c = (bus.cmd_shape == SH_RECT);
    assign is_tri_c  = (bus.cmd_shape == SH_TRI);
    assign is_area_c = (bus.cmd_operation == OP_AREA);
    assign ext_a_c   = RW'(bus.side_a);
    assign ext_b_c   = RW'(bus.side_b);
    assign ext_c_c   = RW'(bus.side_c);

    // Keep encodings and mismatched shape/operation pairs all fall out as illegal.
    always_comb begin
        legal_c = 1'b0;
        unique case (bus.cmd_operation)
            OP_PERIM, OP_AREA: legal_c = is_rect_c || is_tri_c;
            OP_SQ:             legal_c = is_rect_c;
            OP_EQ, OP_ISO:     legal_c = is_tri_c;
            default:           legal_c = 1'b0;
        endcase
    end

    // Results that are ready in the accept cycle.
    always_comb begin
        direct_res_c = '0;
        unique case (bus.cmd_operation)
            OP_PERIM: direct_res_c = is_rect_c ? ((ext_a_c + ext_b_c) << 1)
                                               : (ext_a_c + ext_b_c + ext_c_c);
`ifdef SHAPE_CALC_MUL_1CYC_EN
            OP_AREA:  direct_res_c = is_tri_c ? ((ext_a_c * ext_b_c) >> 1) : (ext_a_c * ext_b_c);
`endif
            OP_SQ:    direct_res_c = RW'(bus.side_a == bus.side_b);
            OP_EQ:    direct_res_c = RW'((bus.side_a == bus.side_b) && (bus.side_b == bus.side_c));
            OP_ISO:   direct_res_c = RW'((bus.side_a == bus.side_b) || (bus.side_b == bus.side_c)
                                         || (bus.side_a == bus.side_c));
            default:  direct_res_c = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
`ifdef SHAPE_CALC_MUL_1CYC_EN
                    state_d = S_DONE;
`else
                    state_d = (legal_c && is_area_c) ? S_MUL : S_DONE;
`endif
                end
            end
`ifndef SHAPE_CALC_MUL_1CYC_EN
            S_MUL:   if (cnt_q == CW'(W - 1)) state_d = S_DONE;
`endif
            S_DONE:  if (bus.res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        res_valid_d = (state_d == S_DONE);
        res_data_d  = res_data_q;
        res_error_d = res_error_q;
`ifndef SHAPE_CALC_MUL_1CYC_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        tri_d    = tri_q;
        sum_c    = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    res_error_d = !legal_c;
                    res_data_d  = legal_c ? direct_res_c : '0;
`ifndef SHAPE_CALC_MUL_1CYC_EN
                    mcand_d  = ext_a_c;
                    mplier_d = bus.side_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    tri_d    = is_tri_c;
`endif
                end
            end
`ifndef SHAPE_CALC_MUL_1CYC_EN
            // One multiplier bit per cycle, LSB first.
            S_MUL: begin
                acc_d    = sum_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    res_data_d  = tri_q ? (sum_c >> 1) : sum_c;
                    res_error_d = 1'b0;
                    cnt_d       = '0;
                end
            end
`endif
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_error_q <= 1'b0;
`ifndef SHAPE_CALC_MUL_1CYC_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            tri_q       <= 1'b0;
`endif
        end else begin
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_error_q <= res_error_d;
`ifndef SHAPE_CALC_MUL_1CYC_EN
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tri_q       <= tri_d;
`endif
        end
    end
endmodule

// File: tb/tb_shape_calc_engine.sv
// Self-checking bench for shape_calc_engine: directed vector table, hand sequences, random vs. reference model.
module tb_shape_calc_engine;
    localparam int unsigned W = 16;
`ifdef SHAPE_CALC_MUL_1CYC_EN
    localparam int LAT_AREA = 1;
`else
    localparam int LAT_AREA = W + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    shape_calc_engine_if #(.W(W)) bus ();

    shape_calc_engine #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  shape;
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model written directly from the arithmetic rules.
    function automatic void ref_calc(input logic [1:0] sh, input logic [4:0] op,
                                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                                     output logic [31:0] d, output logic e, output int lat);
        longint la = longint'(a);
        longint lb = longint'(b);
        longint lc = longint'(c);
        longint r  = 0;
        bit rect = (sh == 2'd1);
        bit tri_s = (sh == 2'd2);
        bit legal = 1'b0;
        if ((op == 5'd0 || op == 5'd1) && (rect || tri_s)) legal = 1'b1;
        if (op == 5'd8 && rect) legal = 1'b1;
        if ((op == 5'd16 || op == 5'd17) && tri_s) legal = 1'b1;
        lat = (legal && op == 5'd1) ? LAT_AREA : 1;
        if (legal) begin
            case (op)
                5'd0:  r = rect ? 2 * (la + lb) : la + lb + lc;
                5'd1:  r = rect ? la * lb : (la * lb) / 2;
                5'd8:  r = (la == lb) ? 1 : 0;
                5'd16: r = (la == lb && lb == lc) ? 1 : 0;
                default: r = (la == lb || lb == lc || la == lc) ? 1 : 0;
            endcase
        end
        d = 32'(r);
        e = !legal;
    endfunction

    // Offer a command and wait until it has been accepted (returns at the negedge after the accept edge).
    task automatic send_cmd(input logic [1:0] sh, input logic [4:0] op,
                            input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                            output bit ok);
        int guard = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_shape = sh; bus.cmd_operation = op;
        bus.side_a = a; bus.side_b = b; bus.side_c = c;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ok = bus.cmd_ready;
        @(negedge clk);
        // Scramble inputs after accept to confirm they were captured.
        bus.cmd_valid = 1'b0; bus.cmd_shape = ~sh; bus.cmd_operation = ~op;
        bus.side_a = ~a; bus.side_b = ~b; bus.side_c = ~c;
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        lat = 1;
        while (!bus.res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ok = bus.res_valid;
    endtask

    task automatic release_result(input int hold);
        repeat (hold) @(negedge clk);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [1:0] sh, input logic [4:0] op,
                                 input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                                 input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                                 input int hold);
        bit ok_acc, ok_val;
        int lat;
        logic [31:0] d;
        logic e;
        send_cmd(sh, op, a, b, c, ok_acc);
        check({name, "_accept"}, 64'(ok_acc), 64'd1);
        if (!ok_acc) return;
        wait_valid(lat, ok_val);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        if (!ok_val) return;
        d = bus.res_data;
        e = bus.res_error;
        check({name, "_data"}, 64'(d), 64'(exp_d));
        check({name, "_error"}, 64'(e), 64'(exp_e));
        release_result(hold);
        check({name, "_handoff"}, {62'd0, bus.res_valid, bus.cmd_ready}, 64'b01);
    endtask

    vec_t vecs[12];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        int lat;
        logic [31:0] ed;
        logic ee;
        int el;

        vecs[0]  = '{2'b01, 5'b00000, 16'd3,      16'd5,      16'd0, 32'd16,         1'b0, 1};
        vecs[1]  = '{2'b10, 5'b00001, 16'd7,      16'd9,      16'd0, 32'd31,         1'b0, LAT_AREA};
        vecs[2]  = '{2'b01, 5'b00001, 16'hFFFF,   16'hFFFF,   16'd0, 32'hFFFE0001,   1'b0, LAT_AREA};
        vecs[3]  = '{2'b01, 5'b10000, 16'd2,      16'd2,      16'd2, 32'd0,          1'b1, 1};
        vecs[4]  = '{2'b11, 5'b00000, 16'd2,      16'd3,      16'd4, 32'd0,          1'b1, 1};
        vecs[5]  = '{2'b01, 5'b00010, 16'd2,      16'd3,      16'd4, 32'd0,          1'b1, 1};
        vecs[6]  = '{2'b10, 5'b00000, 16'hFFFF,   16'hFFFF,   16'hFFFF, 32'h0002FFFD, 1'b0, 1};
        vecs[7]  = '{2'b10, 5'b10000, 16'd5,      16'd5,      16'd5, 32'd1,          1'b0, 1};
        vecs[8]  = '{2'b01, 5'b01000, 16'd3,      16'd4,      16'd0, 32'd0,          1'b0, 1};
        vecs[9]  = '{2'b10, 5'b01000, 16'd3,      16'd3,      16'd3, 32'd0,          1'b1, 1};
        vecs[10] = '{2'b01, 5'b00001, 16'd0,      16'd1234,   16'd0, 32'd0,          1'b0, LAT_AREA};
        vecs[11] = '{2'b10, 5'b11111, 16'd1,      16'd1,      16'd1, 32'd0,          1'b1, 1};

        bus.cmd_valid = 1'b0; bus.cmd_shape = '0; bus.cmd_operation = '0;
        bus.side_a = '0; bus.side_b = '0; bus.side_c = '0; bus.res_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.cmd_ready, bus.res_valid, bus.res_error, bus.res_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_ready", 64'(bus.cmd_ready), 64'd1);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].shape, vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].c, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, i % 3);
        end

        // Backpressure with a stray command pulse while the result is held.
        send_cmd(2'b10, 5'b10001, 16'd4, 16'd6, 16'd4, ok);
        check("bp_accept", 64'(ok), 64'd1);
        wait_valid(lat, ok);
        check("bp_latency", 64'(lat), 64'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.cmd_valid = 1'b1; bus.cmd_shape = 2'b01; bus.cmd_operation = 5'b00000;
                bus.side_a = 16'd100; bus.side_b = 16'd100;
            end
            if (i == 4) bus.cmd_valid = 1'b0;
            check($sformatf("bp_hold%0d", i),
                  {bus.res_valid, bus.cmd_ready, bus.res_error, bus.res_data}, {1'b1, 1'b0, 1'b0, 32'd1});
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("bp_handoff", {62'd0, bus.res_valid, bus.cmd_ready}, 64'b01);
        repeat (3) @(negedge clk);
        check("bp_no_stray", {62'd0, bus.res_valid, bus.cmd_ready}, 64'b01);

        // Reset in the middle of a rectangle area.
        send_cmd(2'b01, 5'b00001, 16'd300, 16'd400, 16'd0, ok);
        check("rst_mid_accept", 64'(ok), 64'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {bus.cmd_ready, bus.res_valid, bus.res_error, bus.res_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_recover", {62'd0, bus.res_valid, bus.cmd_ready}, 64'b01);
        repeat (LAT_AREA + 2) @(negedge clk);
        check("rst_mid_no_stale", 64'(bus.res_valid), 64'd0);
        run_and_check("rst_then_square", 2'b01, 5'b01000, 16'd2, 16'd2, 16'd0, 32'd1, 1'b0, 1, 0);

        // Randomized commands against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [1:0] sh;
            logic [4:0] op;
            logic [15:0] a, b, c;
            int sel;
            sh  = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 6));
            case (sel)
                0: op = 5'd0;
                1: op = 5'd1;
                2: op = 5'd8;
                3: op = 5'd16;
                4: op = 5'd17;
                5: op = 5'd31;
                default: op = 5'($urandom);
            endcase
            if ($urandom_range(0, 1) == 0) begin
                a = 16'($urandom_range(0, 3)); b = 16'($urandom_range(0, 3)); c = 16'($urandom_range(0, 3));
            end else begin
                a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
            end
            ref_calc(sh, op, a, b, c, ed, ee, el);
            run_and_check($sformatf("rnd%0d_sh%0d_op%0d", n, sh, op), sh, op, a, b, c, ed, ee, el,
                          int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shape_calc_engine.md
# shape_calc_engine

- Execution stage directly downstream of the shape processor control SFR.
- Accepts one committed command per handshake: SHAPE and OPERATION fields plus side lengths.
- Checks the shape/operation combination, then computes the result: perimeter, area, or a geometric predicate.
- Returns the result with an error flag over a valid/ready handshake. Area uses a multi-cycle shift-add multiplier unless a single-cycle multiplier is compiled in.

## Interface
- W, 16, width of each side-length input; result width is 2*W; W >= 2.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle, can accept.
- cmd_shape  in  2  SHAPE encoding: 01 rectangle, 10 triangle, 11 keep.
- cmd_operation  in  5  OPERATION encoding: 00000 perimeter, 00001 area, 01000 is_square, 10000 is_equilateral, 10001 is_isosceles, 11111 keep.
- side_a, side_b, side_c  in  W each  unsigned side lengths; side_c is used by triangles only.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  2*W  result value.
- res_error  out  1  illegal combination; res_data = 0.

## Operation
- Command is accepted when cmd_valid && cmd_ready. All cmd_* and side_* inputs are captured at accept; later changes are ignored.
- Legal combinations:
  - perimeter/area with rectangle or triangle;
  - is_square with rectangle only;
  - is_equilateral/is_isosceles with triangle only.
- Anything else is illegal: keep values, reserved encodings, mismatched pairs. Illegal commands give res_error=1, res_data=0.
- Rectangle perimeter = 2*(a+b). Triangle perimeter = a+b+c. Zero-extended, no overflow at 2*W.
- Rectangle area = a*b.
- Triangle area = (a*b)>>1, with a = base and b = height; truncating.
- Predicates return res_data = 1 or 0:
  - is_square: a==b.
  - is_equilateral: a==b && b==c.
  - is_isosceles: a==b || b==c || a==c.
- Zero-length sides are not errors; arithmetic proceeds normally.
- State machine:
  - IDLE: cmd_ready=1. On accept, a legal area command goes to MUL; all other commands load the result and go to DONE.
  - MUL: shift-add over W cycles, one multiplier bit per cycle, LSB first; iteration counter runs 0..W-1. At count W-1, apply the triangle >>1 if needed and go to DONE.
  - DONE: res_valid=1; res_data and res_error held stable. On res_ready, go to IDLE.
- No command is accepted outside IDLE. There is no pipelining: one command in flight.

## Timing
- Reset values: cmd_ready=0 during the reset cycle and 1 in the first cycle after it. res_valid=0, res_data=0, res_error=0. State IDLE, counter 0.
- Non-multiply latency: command accepted at edge N; res_valid=1 in the cycle after edge N.
- Area latency: res_valid rises W+1 cycles after accept (W=16 gives 17).
- res_valid stays high until res_ready is sampled high. Deassertion happens on that edge.
- cmd_ready rises in the same edge that res_valid falls; a new command can be accepted in the next cycle. Minimum command-to-command spacing is 2 cycles.
- res_ready while res_valid=0 is ignored.
- Reset mid-operation (MUL or DONE) aborts immediately. The partial product and pending result are discarded and all outputs return to reset values.

## Configuration
- SHAPE_CALC_MUL_1CYC_EN defined: area uses a combinational W×W multiply. The MUL state and counter are not built. Area latency equals the non-multiply latency (1 cycle).
- Undefined (default): shift-add multiplier as above, with area latency W+1.
- Results are bit-identical in both builds.

## Test plan
- Rectangle perimeter: shape=01, op=00000, a=3, b=5 -> res_data=16, res_error=0, res_valid 1 cycle after accept.
- Triangle area: shape=10, op=00001, a=7, b=9 -> res_data=31. res_valid after 17 cycles (W=16), or 1 cycle with SHAPE_CALC_MUL_1CYC_EN.
- Max rectangle area: a=b=16'hFFFF -> res_data=32'hFFFE0001, no wrap.
- Illegal combinations:
  - shape=01, op=10000 -> res_error=1, res_data=0.
  - shape=11, op=00000 -> res_error=1, res_data=0.
  - op=00010 -> res_error=1, res_data=0.
- Backpressure: hold res_ready=0 for 10 cycles after is_isosceles with a=4, b=6, c=4. res_data stays 1, cmd_ready stays 0, and a cmd_valid pulse in that window is not accepted.
- Reset at MUL cycle 5 of a rectangle area: next cycle res_valid=0 and cmd_ready=1. A following is_square with a=b=2 returns 1.
